// File: rtl/collision_scheduler.sv
// Per-frame collision scan: snapshots car and enemy positions on frame_tick, then
// tests one enemy slot per clock against the car with a single shared overlap comparator.
module collision_scheduler #(
  parameter int N_ENEMY = 4,
  parameter int HIT_W   = 80,
  parameter int HIT_H   = 121,
  parameter int IDX_W   = $clog2(N_ENEMY)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   game_enable,
  input  logic                   frame_tick,
  input  logic [9:0]             car_x,
  input  logic [9:0]             car_y,
  input  logic [10*N_ENEMY-1:0]  enemy_x_bus,
  input  logic [10*N_ENEMY-1:0]  enemy_y_bus,
  input  logic [N_ENEMY-1:0]     enemy_valid,
  input  logic                   clear_collision,
  output logic                   busy,
  output logic                   scan_done,
  output logic                   collision,
  output logic [IDX_W-1:0]       hit_index,
  output logic                   overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENEMY - 1);

  state_t             state_q;
  logic [9:0]         car_x_q, car_y_q;
  logic [9:0]         ex_q [N_ENEMY];
  logic [9:0]         ey_q [N_ENEMY];
  logic [N_ENEMY-1:0] valid_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   first_idx_q;
  logic               frame_hit_q;

  logic [10:0] cx, cy, ex, ey;
  logic        slot_hit;

  // 11-bit operands keep position + hitbox sums from wrapping at the screen edge.
  always_comb begin
    cx       = {1'b0, car_x_q};
    cy       = {1'b0, car_y_q};
    ex       = {1'b0, ex_q[idx_q]};
    ey       = {1'b0, ey_q[idx_q]};
    slot_hit = valid_q[idx_q]
             && (cx <= ex + 11'(HIT_W)) && (ex <= cx + 11'(HIT_W))
             && (cy <= ey + 11'(HIT_H)) && (ey <= cy + 11'(HIT_H));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      car_x_q     <= '0;
      car_y_q     <= '0;
      valid_q     <= '0;
      idx_q       <= '0;
      first_idx_q <= '0;
      frame_hit_q <= 1'b0;
      busy        <= 1'b0;
      scan_done   <= 1'b0;
      collision   <= 1'b0;
      hit_index   <= '0;
      overrun     <= 1'b0;
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
        ex_q[i] <= '0;
        ey_q[i] <= '0;
      end
    end else begin
      scan_done <= 1'b0;

      if (frame_tick && state_q != IDLE)
        overrun <= 1'b1;

      case (state_q)
        IDLE: begin
          if (frame_tick && game_enable) begin
            car_x_q     <= car_x;
            car_y_q     <= car_y;
            valid_q     <= enemy_valid;
            for (int unsigned i = 0; i < N_ENEMY; i++) begin
              ex_q[i] <= enemy_x_bus[10*i +: 10];
              ey_q[i] <= enemy_y_bus[10*i +: 10];
            end
            idx_q       <= '0;
            frame_hit_q <= 1'b0;
            busy        <= 1'b1;
            state_q     <= SCAN;
          end
        end
        SCAN: begin
          if (slot_hit && !frame_hit_q) begin
            frame_hit_q <= 1'b1;
            first_idx_q <= idx_q;
          end
          if (idx_q == LAST_IDX) begin
            scan_done <= 1'b1;
            state_q   <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase

      // A fresh latch at DONE exit takes priority over a coincident clear.
      if (state_q == DONE && frame_hit_q && !collision) begin
        collision <= 1'b1;
        hit_index <= first_idx_q;
      end else if (clear_collision) begin
        collision <= 1'b0;
        hit_index <= '0;
      end
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler: per-cycle timing, hitbox boundaries,
// sticky flag/index behaviour, overrun, mid-scan reset and clear priority.
module tb_collision_scheduler;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            game_enable;
  logic            frame_tick;
  logic [9:0]      car_x, car_y;
  logic [10*N-1:0] enemy_x_bus, enemy_y_bus;
  logic [N-1:0]    enemy_valid;
  logic            clear_collision;
  logic            busy, scan_done, collision, overrun;
  logic [1:0]      hit_index;

  int tests = 0;
  int fails = 0;

  collision_scheduler #(.N_ENEMY(N), .HIT_W(80), .HIT_H(121)) dut (
    .clk(clk), .reset(reset), .game_enable(game_enable), .frame_tick(frame_tick),
    .car_x(car_x), .car_y(car_y), .enemy_x_bus(enemy_x_bus), .enemy_y_bus(enemy_y_bus),
    .enemy_valid(enemy_valid), .clear_collision(clear_collision), .busy(busy),
    .scan_done(scan_done), .collision(collision), .hit_index(hit_index), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input int x, input int y, input bit v);
    enemy_x_bus[10*i +: 10] = 10'(x);
    enemy_y_bus[10*i +: 10] = 10'(y);
    enemy_valid[i]          = v;
  endtask

  task automatic clear_slots();
    for (int i = 0; i < N; i++) set_slot(i, 600, 10, 1'b0);
  endtask

  // One full frame: tick at E0, checks busy/scan_done every cycle, results after E_(N+1).
  task automatic run_scan(input string tag, input bit exp_col, input int exp_idx,
                          input bit clr_at_done);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    check({tag, "_done_e0"}, 32'(scan_done), 32'd0);
    for (int k = 1; k <= N; k++) begin
      step();
      check({tag, "_busy_scan"}, 32'(busy), 32'd1);
      check({tag, "_done_scan"}, 32'(scan_done), 32'(k == N));
      if (k == N) clear_collision = clr_at_done;
    end
    step();
    clear_collision = 1'b0;
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_done_end"}, 32'(scan_done), 32'd0);
    check({tag, "_collision"}, 32'(collision), 32'(exp_col));
    check({tag, "_hit_index"}, 32'(hit_index), 32'(exp_idx));
  endtask

  task automatic pulse_clear(input string tag);
    clear_collision = 1'b1;
    step();
    clear_collision = 1'b0;
    check({tag, "_collision"}, 32'(collision), 32'd0);
    check({tag, "_hit_index"}, 32'(hit_index), 32'd0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; game_enable = 1'b1; frame_tick = 1'b0; clear_collision = 1'b0;
    car_x = 10'd100; car_y = 10'd300;
    enemy_x_bus = '0; enemy_y_bus = '0; enemy_valid = '0;
    clear_slots();
    step(); step();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(scan_done), 32'd0);
    check("rst_collision", 32'(collision), 32'd0);
    check("rst_hit_index", 32'(hit_index), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Basic hit on slot 0
    set_slot(0, 150, 350, 1'b1);
    run_scan("basic", 1'b1, 0, 1'b0);
    pulse_clear("clr_idle");

    // game_enable low: tick ignored
    game_enable = 1'b0;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check("disabled_busy", 32'(busy), 32'd0);
    game_enable = 1'b1;

    // X and Y hitbox boundaries on slot 1
    clear_slots();
    set_slot(1, 180, 300, 1'b1);
    run_scan("x_edge_hit", 1'b1, 1, 1'b0);
    pulse_clear("clr_x");
    set_slot(1, 181, 300, 1'b1);
    run_scan("x_edge_miss", 1'b0, 0, 1'b0);
    set_slot(1, 100, 421, 1'b1);
    run_scan("y_edge_hit", 1'b1, 1, 1'b0);
    pulse_clear("clr_y");
    set_slot(1, 100, 422, 1'b1);
    run_scan("y_edge_miss", 1'b0, 0, 1'b0);

    // First hit wins, index frozen while sticky
    clear_slots();
    set_slot(1, 100, 300, 1'b1);
    set_slot(3, 120, 320, 1'b1);
    run_scan("multi_hit", 1'b1, 1, 1'b0);
    set_slot(1, 100, 300, 1'b0);
    run_scan("sticky", 1'b1, 1, 1'b0);
    pulse_clear("clr_sticky");

    // Near screen edge: sums must not wrap
    clear_slots();
    car_x = 10'd950; car_y = 10'd900;
    set_slot(2, 1000, 1000, 1'b1);
    run_scan("nowrap_hit", 1'b1, 2, 1'b0);
    pulse_clear("clr_nowrap");
    set_slot(2, 1000, 1000, 1'b0);
    run_scan("nowrap_invalid", 1'b0, 0, 1'b0);

    // Live inputs change mid-scan; snapshot must be used
    car_x = 10'd100; car_y = 10'd300;
    clear_slots();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    set_slot(0, 100, 300, 1'b1);
    for (int k = 0; k < N + 1; k++) step();
    check("snapshot_collision", 32'(collision), 32'd0);
    clear_slots();

    // Overrun: second tick two cycles into the scan is dropped
    check("pre_overrun", 32'(overrun), 32'd0);
    pulses = 0;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (scan_done) pulses++;
      step();
    end
    check("overrun_flag", 32'(overrun), 32'd1);
    check("overrun_one_done", 32'(pulses), 32'd1);

    // Reset mid-scan discards the partial result
    set_slot(0, 100, 300, 1'b1);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(scan_done), 32'd0);
    check("midrst_collision", 32'(collision), 32'd0);
    check("midrst_hit_index", 32'(hit_index), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (scan_done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    check("midrst_no_collision", 32'(collision), 32'd0);

    // Set beats a coincident clear
    clear_slots();
    set_slot(3, 60, 250, 1'b1);
    run_scan("set_beats_clear", 1'b1, 3, 1'b1);
    pulse_clear("clr_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Time-multiplexed collision controller for the race game. Once per video frame it snapshots the player car position and up to N_ENEMY enemy positions. It then checks each enemy against the car with one shared overlap comparator, one slot per clock. It reports a sticky crash flag, the index of the first enemy hit, and a per-frame completion pulse to the game-state logic. It sits between the sprite-position registers and the game FSM, and replaces per-enemy comparator instances.

## Interface
- N_ENEMY, 4: number of enemy slots scanned per frame (2..8).
- HIT_W, 80: horizontal hitbox extent in pixels (car and enemy identical).
- HIT_H, 121: vertical hitbox extent in pixels.
- IDX_W, $clog2(N_ENEMY): width of hit_index.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clock clk.
- game_enable  in  1  when low, frame_tick is ignored.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- car_x, car_y  in  10 each  player car top-left position.
- enemy_x_bus, enemy_y_bus  in  10*N_ENEMY each  slot i occupies bits [10*i+9:10*i].
- enemy_valid  in  N_ENEMY  slot i takes part in the scan only when its bit is 1.
- clear_collision  in  1  one-cycle pulse that clears the sticky crash state.
- busy  out  1  high while a scan is in progress.
- scan_done  out  1  one-cycle pulse when a scan completes.
- collision  out  1  sticky crash flag.
- hit_index  out  IDX_W  lowest enemy index that caused the latched collision.
- overrun  out  1  sticky flag: a frame_tick arrived while busy.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On an edge with frame_tick=1 and game_enable=1, snapshot car_x, car_y, both enemy buses and enemy_valid into internal registers.
  - On the same edge: idx<=0, frame_hit<=0, state<=SCAN.
- SCAN:
  - Each edge evaluates snapshot slot idx only; live inputs are not used during the scan.
  - The slot overlaps when valid and all four hold: car_x <= ex+HIT_W, ex <= car_x+HIT_W, car_y <= ey+HIT_H, ey <= car_y+HIT_H.
  - Comparisons use 11-bit zero-extended operands, so sums never wrap.
  - On the first overlapping slot of the frame: frame_hit<=1 and the slot index is recorded. Later overlaps in the same frame do not change the recorded index.
  - Invalid slots still consume one cycle, so latency is fixed.
  - After slot N_ENEMY-1: state<=DONE.
- DONE:
  - If frame_hit=1 and collision=0: collision<=1 and hit_index<=recorded index.
  - If collision is already 1: collision stays 1 and hit_index is frozen.
  - state<=IDLE.
- clear_collision:
  - Any state: collision<=0 and hit_index<=0 on the next edge.
  - If the DONE update sets collision on the same edge, the set wins.
- overrun:
  - Set when frame_tick=1 while the state is not IDLE. That tick is discarded, not queued.
  - Cleared only by reset.
- reset:
  - State IDLE; busy, scan_done, collision, hit_index and overrun all 0; snapshot registers 0.
  - Applies mid-scan too; the partial result is discarded.

## Timing
- Edge E0 samples frame_tick.
- busy is high in the cycles after edges E0 through E_N (N_ENEMY+1 cycles).
- Slot i is evaluated at edge E_(i+1).
- At edge E_N: DONE entered, scan_done=1 for the following cycle, collision/hit_index updated at the DONE exit edge E_(N+1).
- Result latency from frame_tick to collision valid: N_ENEMY+2 edges (6 for the default).
- At E_(N+1): back in IDLE, busy=0. A frame_tick sampled at E_(N+1) or later starts a new scan.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Car (100,300), enemy0 (150,350) valid, others invalid; frame_tick -> scan_done 5 cycles later; collision=1 and hit_index=0 at edge 6; busy high for exactly 5 cycles.
- X boundary: car (100,300), enemy1 at (180,300) -> hit; enemy1 at (181,300) -> no hit. Y boundary: enemy1 at (100,421) -> hit; (100,422) -> no hit.
- Enemies 1 and 3 both overlapping -> hit_index=1; next frame with only enemy 3 overlapping -> hit_index stays 1 while collision is sticky.
- No wrap: car (950,900), enemy2 (1000,1000) -> hit. Same positions with enemy_valid[2]=0 -> no hit, scan_done still at the same cycle.
- frame_tick repeated 2 cycles after the first -> overrun=1, only one scan_done. Reset asserted mid-scan -> all outputs 0, no scan_done.
- clear_collision pulsed on the same edge as a DONE update with a hit -> collision remains 1. Clear with no hit pending -> collision=0 and hit_index=0.
